// File: rtl/mas_mcycle_unit.sv
// mas_mcycle_unit
// Shared signed multiply-add/subtract responder for the FOC PI controllers.
// A one-cycle mas_en_i strobe captures the operands while idle. The datapath
// is then held for g_NO_MCYCLE_PATH cycles (a declared multi-cycle path from
// the operand registers to the result register). After that, a*b+c or a*b-c is
// registered together with a single-cycle mas_done_o pulse.
//
// Ports
//   sys_clk_i   system clock, rising edge
//   reset_i     synchronous reset, active-high
//   mas_en_i    request strobe, sampled only while idle
//   sub_i       0: a*b + c, 1: a*b - c
//   mul_a_i     signed multiplicand  [g_STD_IO_WIDTH]
//   mul_b_i     signed multiplier    [g_STD_IO_WIDTH]
//   add_c_i     signed addend        [g_ADD_C_WIDTH]
//   product_o   registered result    [g_ADD_C_WIDTH]
//   mas_done_o  one-cycle completion pulse
//   busy_o      operation in flight
//   ovf_o       last result wrapped, registered with product_o
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for mas_en_i; result and flags hold their last value
// ST_CALC | operands captured, counting down the multi-cycle path budget

module mas_mcycle_unit #(
    parameter int g_STD_IO_WIDTH   = 18,
    parameter int g_ADD_C_WIDTH    = 44,
    parameter int g_NO_MCYCLE_PATH = 2
) (
    input  logic                             sys_clk_i,
    input  logic                             reset_i,
    input  logic                             mas_en_i,
    input  logic                             sub_i,
    input  logic signed [g_STD_IO_WIDTH-1:0] mul_a_i,
    input  logic signed [g_STD_IO_WIDTH-1:0] mul_b_i,
    input  logic signed [g_ADD_C_WIDTH-1:0]  add_c_i,
    output logic signed [g_ADD_C_WIDTH-1:0]  product_o,
    output logic                             mas_done_o,
    output logic                             busy_o,
    output logic                             ovf_o
);

    localparam int c_MUL_W = 2 * g_STD_IO_WIDTH;
    localparam int c_SUM_W = g_ADD_C_WIDTH + 1;
    // A one-bit counter is kept even when the budget is a single cycle.
    localparam int c_CNT_W = (g_NO_MCYCLE_PATH > 1) ? $clog2(g_NO_MCYCLE_PATH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(g_NO_MCYCLE_PATH - 1);

    if (g_NO_MCYCLE_PATH < 1) begin : g_bad_path
        $error("mas_mcycle_unit: g_NO_MCYCLE_PATH must be >= 1");
    end
    if (g_ADD_C_WIDTH < c_MUL_W + 1) begin : g_bad_width
        $error("mas_mcycle_unit: g_ADD_C_WIDTH must be >= 2*g_STD_IO_WIDTH+1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [c_CNT_W-1:0] cnt_q;
    logic               accept;
    logic               finish;

    logic signed [g_STD_IO_WIDTH-1:0] a_q;
    logic signed [g_STD_IO_WIDTH-1:0] b_q;
    logic signed [g_ADD_C_WIDTH-1:0]  c_q;
    logic                             sub_q;

    logic signed [c_MUL_W-1:0] mul;
    logic signed [c_SUM_W-1:0] mul_ext;
    logic signed [c_SUM_W-1:0] c_ext;
    logic signed [c_SUM_W-1:0] sum;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mas_en_i) state_d = ST_CALC;
            ST_CALC: if (cnt_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o = (state_q == ST_CALC);
        accept = (state_q == ST_IDLE) && mas_en_i;
        finish = (state_q == ST_CALC) && (cnt_q == '0);
    end

    // Terminal-count down-counter for the multi-cycle budget.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= c_CNT_LOAD;
        end else if ((state_q == ST_CALC) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Operand registers need no reset: they are only consumed after a capture.
    always_ff @(posedge sys_clk_i) begin
        if (!reset_i && accept) begin
            a_q   <= mul_a_i;
            b_q   <= mul_b_i;
            c_q   <= add_c_i;
            sub_q <= sub_i;
        end
    end

    // Arithmetic is one bit wider than the result so the wrap can be seen.
    // It is a multi-cycle path from the operand registers to the result register.
    always_comb begin
        mul     = a_q * b_q;
        mul_ext = {{(c_SUM_W - c_MUL_W){mul[c_MUL_W-1]}}, mul};
        c_ext   = {c_q[g_ADD_C_WIDTH-1], c_q};
        sum     = sub_q ? (mul_ext - c_ext) : (mul_ext + c_ext);
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            product_o  <= '0;
            ovf_o      <= 1'b0;
            mas_done_o <= 1'b0;
        end else begin
            mas_done_o <= finish;
            if (finish) begin
                product_o <= sum[g_ADD_C_WIDTH-1:0];
                ovf_o     <= sum[c_SUM_W-1] ^ sum[c_SUM_W-2];
            end
        end
    end

endmodule

// File: tb/tb_mas_mcycle_unit.sv
module tb_mas_mcycle_unit;

    localparam int S = 18;
    localparam int W = 44;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, en0, en1, sub;
    logic signed [S-1:0] a, b;
    logic signed [W-1:0] c;

    logic signed [W-1:0] p0, p1;
    logic done0, busy0, ovf0, done1, busy1, ovf1;

    int checks = 0;
    int errors = 0;

    logic [W:0] q0[$];
    logic [W:0] q1[$];
    logic [W:0] e0, e1;

    mas_mcycle_unit #(.g_STD_IO_WIDTH(S), .g_ADD_C_WIDTH(W), .g_NO_MCYCLE_PATH(2)) u_dut0 (
        .sys_clk_i(clk), .reset_i(rst0), .mas_en_i(en0), .sub_i(sub),
        .mul_a_i(a), .mul_b_i(b), .add_c_i(c),
        .product_o(p0), .mas_done_o(done0), .busy_o(busy0), .ovf_o(ovf0));

    mas_mcycle_unit #(.g_STD_IO_WIDTH(S), .g_ADD_C_WIDTH(W), .g_NO_MCYCLE_PATH(1)) u_dut1 (
        .sys_clk_i(clk), .reset_i(rst1), .mas_en_i(en1), .sub_i(sub),
        .mul_a_i(a), .mul_b_i(b), .add_c_i(c),
        .product_o(p1), .mas_done_o(done1), .busy_o(busy1), .ovf_o(ovf1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, wrap detected by range check.
    function automatic logic [W:0] model(input longint av, input longint bv,
                                         input longint cv, input bit s);
        longint r;
        longint lim;
        logic   o;
        lim = longint'(1) <<< (W - 1);
        r   = s ? (av * bv - cv) : (av * bv + cv);
        o   = (r > lim - 1) || (r < -lim);
        return {o, r[W-1:0]};
    endfunction

    // Scoreboard monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (done0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_done actual=1 required=0");
            end else begin
                e0 = q0.pop_front();
                if ({ovf0, p0} !== e0) begin
                    errors++;
                    $display("FAIL dut0_result actual=%0h required=%0h", {ovf0, p0}, e0);
                end
            end
        end
        if (done1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_done actual=1 required=0");
            end else begin
                e1 = q1.pop_front();
                if ({ovf1, p1} !== e1) begin
                    errors++;
                    $display("FAIL dut1_result actual=%0h required=%0h", {ovf1, p1}, e1);
                end
            end
        end
    end

    // Single request on dut0 with the inputs scrambled after capture.
    // Returns just after the expected done edge.
    task automatic req0(input logic signed [S-1:0] av, input logic signed [S-1:0] bv,
                        input logic signed [W-1:0] cv, input logic s);
        a = av; b = bv; c = cv; sub = s; en0 = 1'b1;
        step();
        en0 = 1'b0; a = ~av; b = ~bv; c = ~cv; sub = ~s;
        step();
        step();
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        a = '0; b = '0; c = '0; sub = 1'b0;
        step();
        step();
        chk("rst_dut0_outputs", {p0, done0, busy0, ovf0}, 64'd0);
        chk("rst_dut1_outputs", {p1, done1, busy1, ovf1}, 64'd0);

        // A request during reset is ignored.
        en0 = 1'b1; a = 18'sd3; b = 18'sd3;
        step();
        chk("rst_ignores_en", busy0, 64'd0);
        en0 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
        step();

        // Test 1: cycle-exact timing, 100*-3+1000 = 700
        a = 18'sd100; b = -18'sd3; c = 44'sd1000; sub = 1'b0; en0 = 1'b1;
        q0.push_back({1'b0, 44'd700});
        step();
        chk("t1_busy_e0", busy0, 64'd1);
        chk("t1_done_e0", done0, 64'd0);
        en0 = 1'b0; a = 18'sd5; b = 18'sd5; c = 44'sd9;
        step();
        chk("t1_busy_e1", busy0, 64'd1);
        chk("t1_done_e1", done0, 64'd0);
        step();
        chk("t1_done_e2", done0, 64'd1);
        chk("t1_busy_e2", busy0, 64'd0);
        chk("t1_product", p0, 64'd700);
        step();
        chk("t1_done_e3", done0, 64'd0);
        chk("t1_hold", p0, 64'd700);

        // Test 2: (-2^17)^2 - 5 = 2^34 - 5
        q0.push_back({1'b0, 44'd17179869179});
        req0(-18'sd131072, -18'sd131072, 44'sd5, 1'b1);
        chk("t2_done", done0, 64'd1);

        // Test 3: 1 + (2^43-1) wraps to -2^43, then a clean 6 issued in the done cycle
        q0.push_back({1'b1, 44'h800_0000_0000});
        req0(18'sd1, 18'sd1, 44'sh7FF_FFFF_FFFF, 1'b0);
        chk("t3_wrap_done", done0, 64'd1);
        chk("t3_wrap_ovf", ovf0, 64'd1);
        q0.push_back({1'b0, 44'd6});
        req0(18'sd2, 18'sd3, 44'sd0, 1'b0);
        chk("t3_next_done", done0, 64'd1);
        chk("t3_next_ovf", ovf0, 64'd0);
        step();

        // Test 4: mas_en held high, accepts every third edge
        for (int i = 0; i < 10; i++) begin
            a = S'(10 + i); b = S'(-(i + 1)); c = W'(i * 1000); sub = i[0];
            en0 = 1'b1;
            if (i % 3 == 0) q0.push_back(model(10 + i, -(i + 1), i * 1000, i[0]));
            step();
            chk($sformatf("t4_done_e%0d", i), done0, {63'd0, (i == 2 || i == 5 || i == 8)});
        end
        en0 = 1'b0;
        step();
        step();
        chk("t4_done_e11", done0, 64'd1);
        step();

        // Test 5: reset aborts an operation, then a fresh request completes
        a = 18'sd3; b = 18'sd4; c = 44'sd0; sub = 1'b0; en0 = 1'b1;
        step();
        chk("t5_busy_e0", busy0, 64'd1);
        en0 = 1'b0; rst0 = 1'b1;
        step();
        chk("t5_rst_outputs", {p0, done0, busy0, ovf0}, 64'd0);
        rst0 = 1'b0;
        step();
        chk("t5_no_done_e2", done0, 64'd0);
        a = -18'sd5; b = 18'sd6; c = 44'sd100; sub = 1'b0; en0 = 1'b1;
        q0.push_back({1'b0, 44'd70});
        step();
        en0 = 1'b0;
        chk("t5_busy_e3", busy0, 64'd1);
        step();
        chk("t5_hold_zero", p0, 64'd0);
        step();
        chk("t5_done_e5", done0, 64'd1);
        chk("t5_product", p0, 64'd70);
        step();

        // Test 6: single-cycle budget on dut1, 7*-8 - (-4) = -52
        a = 18'sd7; b = -18'sd8; c = -44'sd4; sub = 1'b1; en1 = 1'b1;
        q1.push_back({1'b0, -44'sd52});
        step();
        en1 = 1'b0;
        chk("t6_busy_e0", busy1, 64'd1);
        chk("t6_done_e0", done1, 64'd0);
        step();
        chk("t6_done_e1", done1, 64'd1);
        chk("t6_busy_e1", busy1, 64'd0);
        chk("t6_product", p1, {20'hFFFFF, -44'sd52});
        for (int i = 0; i < 6; i++) begin
            a = S'(i * 100 - 7); b = S'(i + 3); c = W'(-i); sub = i[0];
            en1 = 1'b1;
            if (i % 2 == 0) q1.push_back(model(i * 100 - 7, i + 3, -i, i[0]));
            step();
            chk($sformatf("t6_b2b_done_e%0d", i), done1, {63'd0, i[0]});
        end
        en1 = 1'b0;
        step();
        chk("t6_done_after", done1, 64'd0);

        step();
        step();
        chk("q0_drained", q0.size(), 64'd0);
        chk("q1_drained", q1.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
